// File: rtl/axi_frame_sched_if.sv
// axi_frame_sched_if: AXI3 address and write-response channel bundle for the frame scheduler
interface axi_frame_sched_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        bvalid;
    logic        bready;
    modport master (output awvalid, awaddr, arvalid, araddr, bready, input awready, arready, bvalid);
    modport slave (input awvalid, awaddr, arvalid, araddr, bready, output awready, arready, bvalid);
endinterface

// File: rtl/axi_frame_sched.sv
// axi_frame_sched: shares one AXI3 AW/AR pair between the frame writer and the previous-frame reader
module axi_frame_sched #(
    parameter int          H_WIDTH  = 1920,
    parameter int          V_HEIGHT = 1080,
    parameter logic [31:0] BASE     = 32'h2000000,
    parameter int          MAX_OUT  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vs_i,
    input  logic              wen_i,
    input  logic              ren_i,
    input  logic              wr_req_i,
    input  logic              wr_urgent_i,
    input  logic              rd_req_i,
    input  logic              rd_last_i,
    output logic              wr_gnt_o,
    output logic              rd_gnt_o,
    output logic              rd_frame_ok_o,
    output logic              err_o,
    axi_frame_sched_if.master m_axi
);
    localparam int              FRAME_BYTES = H_WIDTH * V_HEIGHT * 4;
    localparam int              BURSTS      = H_WIDTH * V_HEIGHT / 32;
    localparam int              CW          = $clog2(BURSTS + 1);
    localparam logic [CW-1:0]   BURSTS_C    = CW'(BURSTS);
    localparam logic [3:0]      MAX_C       = 4'(MAX_OUT);
    localparam logic [31:0]     BASE1       = BASE + 32'(FRAME_BYTES);
    localparam logic [31:0]     BURST_BYTES = 32'd128;

    typedef enum logic [1:0] {IDLE, AW, AR} state_t;

    state_t        state, state_n;
    logic          vs_q, vs_pend, wr_slot, rd_slot, last_was_wr;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic [3:0]    wr_out, rd_out;
    logic [31:0]   wr_off, rd_off;
    logic          wr_ok, rd_ok, pick_wr, pick_rd, swap;

    assign wr_ok   = wen_i & wr_req_i & (wr_cnt < BURSTS_C) & (wr_out < MAX_C) & ~vs_pend;
    assign rd_ok   = ren_i & rd_req_i & rd_frame_ok_o & (rd_cnt < BURSTS_C) & (rd_out < MAX_C) & ~vs_pend;
    // eligibility already excludes vs_pend, so a pending swap always beats a grant
    assign swap    = (state == IDLE) & vs_pend;
    assign pick_wr = (state == IDLE) & wr_ok & (wr_urgent_i | ~rd_ok | ~last_was_wr);
    assign pick_rd = (state == IDLE) & rd_ok & ~pick_wr;

    always_comb begin
        state_n       = state;
        m_axi.awvalid = 1'b0;
        m_axi.arvalid = 1'b0;
        wr_gnt_o      = 1'b0;
        rd_gnt_o      = 1'b0;
        case (state)
            IDLE: state_n = pick_wr ? AW : pick_rd ? AR : IDLE;
            AW: begin
                m_axi.awvalid = 1'b1;
                wr_gnt_o      = m_axi.awready;
                state_n       = m_axi.awready ? IDLE : AW;
            end
            AR: begin
                m_axi.arvalid = 1'b1;
                rd_gnt_o      = m_axi.arready;
                state_n       = m_axi.arready ? IDLE : AR;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            vs_q          <= 1'b0;
            vs_pend       <= 1'b0;
            wr_slot       <= 1'b0;
            rd_slot       <= 1'b1;
            last_was_wr   <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            wr_out        <= '0;
            rd_out        <= '0;
            wr_off        <= '0;
            rd_off        <= '0;
            m_axi.awaddr  <= '0;
            m_axi.araddr  <= '0;
            m_axi.bready  <= 1'b0;
            rd_frame_ok_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state        <= state_n;
            vs_q         <= vs_i;
            vs_pend      <= (vs_i & ~vs_q) | (vs_pend & ~swap);
            m_axi.bready <= 1'b1;
            wr_out       <= wr_out + {3'b0, wr_gnt_o} - {3'b0, m_axi.bvalid & (wr_out != '0)};
            rd_out       <= rd_out + {3'b0, rd_gnt_o} - {3'b0, rd_last_i & (rd_out != '0)};
            if (swap) begin
                rd_slot       <= wr_slot;
                wr_slot       <= ~wr_slot;
                rd_frame_ok_o <= wr_cnt == BURSTS_C;
                err_o         <= err_o | (wr_cnt != BURSTS_C);
                wr_cnt        <= '0;
                rd_cnt        <= '0;
                wr_off        <= '0;
                rd_off        <= '0;
            end
            // running offsets track cnt*128 so no multiplier is needed
            if (pick_wr) m_axi.awaddr <= (wr_slot ? BASE1 : BASE) + wr_off;
            if (pick_rd) m_axi.araddr <= (rd_slot ? BASE1 : BASE) + rd_off;
            if (wr_gnt_o) begin
                wr_cnt      <= wr_cnt + 1'b1;
                wr_off      <= wr_off + BURST_BYTES;
                last_was_wr <= 1'b1;
            end
            if (rd_gnt_o) begin
                rd_cnt      <= rd_cnt + 1'b1;
                rd_off      <= rd_off + BURST_BYTES;
                last_was_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_frame_sched.sv
// tb_axi_frame_sched: directed table plus hand-written corner sequences for axi_frame_sched
module tb_axi_frame_sched;
    localparam logic [31:0] A0 = 32'h2000000;

    typedef struct {
        logic [6:0]  in;
        logic        awv;
        logic [31:0] awa;
        logic        arv;
        logic [31:0] ara;
        logic [3:0]  o;
    } vec_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
    } gr_t;

    logic clk = 1'b0, rst_n = 1'b0, vs = 1'b0, wen = 1'b1, ren = 1'b1;
    logic wr_req = 1'b0, wr_urg = 1'b0, rd_req = 1'b0, rd_last = 1'b0;
    logic wr_gnt, rd_gnt, ok, err;
    int   n_chk = 0, n_fail = 0, n_aw;
    vec_t tv[19];
    gr_t  gq[$], eq[$];

    axi_frame_sched_if bus();

    axi_frame_sched #(.H_WIDTH(64), .V_HEIGHT(2), .BASE(A0), .MAX_OUT(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .vs_i(vs), .wen_i(wen), .ren_i(ren),
        .wr_req_i(wr_req), .wr_urgent_i(wr_urg), .rd_req_i(rd_req), .rd_last_i(rd_last),
        .wr_gnt_o(wr_gnt), .rd_gnt_o(rd_gnt), .rd_frame_ok_o(ok), .err_o(err), .m_axi(bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (wr_gnt) gq.push_back('{1'b1, bus.awaddr});
            if (rd_gnt) gq.push_back('{1'b0, bus.araddr});
            tick();
        end
    endtask

    task automatic cmp_q(input string name);
        chk32({name, " grant count"}, gq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < gq.size(); i++) begin
            chk1($sformatf("%s[%0d] is write", name, i), gq[i].w, eq[i].w);
            chk32($sformatf("%s[%0d] addr", name, i), gq[i].a, eq[i].a);
        end
        gq.delete();
        eq.delete();
    endtask

    task automatic do_vsync();
        wr_req = 1'b0;
        rd_req = 1'b0;
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        tick();
    endtask

    initial begin
        // in = {vs, wr_req, rd_req, awready, arready, bvalid, rd_last}; o = {wr_gnt, rd_gnt, ok, err}
        tv[0]  = '{7'b0101000, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[1]  = '{7'b0101000, 1'b1, A0,           1'b0, 32'h0,       4'b1000};
        tv[2]  = '{7'b0101010, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[3]  = '{7'b0101000, 1'b1, A0 + 32'h80,  1'b0, 32'h0,       4'b1000};
        tv[4]  = '{7'b0101010, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[5]  = '{7'b0101000, 1'b1, A0 + 32'h100, 1'b0, 32'h0,       4'b1000};
        tv[6]  = '{7'b0101010, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[7]  = '{7'b0101000, 1'b1, A0 + 32'h180, 1'b0, 32'h0,       4'b1000};
        tv[8]  = '{7'b0101010, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[9]  = '{7'b0101000, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[10] = '{7'b1101000, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[11] = '{7'b1101000, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0000};
        tv[12] = '{7'b0010100, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0010};
        tv[13] = '{7'b0010100, 1'b0, 32'h0,        1'b1, A0,          4'b0110};
        tv[14] = '{7'b0010101, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0010};
        tv[15] = '{7'b0010100, 1'b0, 32'h0,        1'b1, A0 + 32'h80, 4'b0110};
        tv[16] = '{7'b0101001, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0010};
        tv[17] = '{7'b0101000, 1'b1, A0 + 32'h200, 1'b0, 32'h0,       4'b1010};
        tv[18] = '{7'b0000010, 1'b0, 32'h0,        1'b0, 32'h0,       4'b0010};
        bus.awready = 1'b0;
        bus.arready = 1'b0;
        bus.bvalid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk1("reset awvalid", bus.awvalid, 1'b0);
        chk1("reset arvalid", bus.arvalid, 1'b0);
        chk32("reset awaddr", bus.awaddr, 32'h0);
        chk32("reset araddr", bus.araddr, 32'h0);
        chk1("reset bready", bus.bready, 1'b0);
        chk1("reset rd_frame_ok", ok, 1'b0);
        chk1("reset err", err, 1'b0);
        tick();
        for (int i = 0; i < 19; i++) begin
            {vs, wr_req, rd_req, bus.awready, bus.arready, bus.bvalid, rd_last} = tv[i].in;
            #1;
            chk1($sformatf("row%0d awvalid", i), bus.awvalid, tv[i].awv);
            chk1($sformatf("row%0d arvalid", i), bus.arvalid, tv[i].arv);
            if (tv[i].awv) chk32($sformatf("row%0d awaddr", i), bus.awaddr, tv[i].awa);
            if (tv[i].arv) chk32($sformatf("row%0d araddr", i), bus.araddr, tv[i].ara);
            chk1($sformatf("row%0d wr_gnt", i), wr_gnt, tv[i].o[3]);
            chk1($sformatf("row%0d rd_gnt", i), rd_gnt, tv[i].o[2]);
            chk1($sformatf("row%0d rd_frame_ok", i), ok, tv[i].o[1]);
            chk1($sformatf("row%0d err", i), err, tv[i].o[0]);
            tick();
        end
        chk1("bready after reset", bus.bready, 1'b1);

        // fair alternation, starting with read because the last grant was a write
        {wr_req, rd_req, bus.awready, bus.arready, bus.bvalid, rd_last} = 6'b111111;
        run(12);
        eq.push_back('{1'b0, A0 + 32'h100});
        eq.push_back('{1'b1, A0 + 32'h280});
        eq.push_back('{1'b0, A0 + 32'h180});
        eq.push_back('{1'b1, A0 + 32'h300});
        eq.push_back('{1'b1, A0 + 32'h380});
        cmp_q("alternate");
        do_vsync();
        #1;
        chk1("swap2 rd_frame_ok", ok, 1'b1);
        chk1("swap2 err", err, 1'b0);

        // urgent writes take every grant until the frame's write quota is used up
        {wr_req, rd_req, wr_urg} = 3'b111;
        run(12);
        eq.push_back('{1'b1, A0});
        eq.push_back('{1'b1, A0 + 32'h80});
        eq.push_back('{1'b1, A0 + 32'h100});
        eq.push_back('{1'b1, A0 + 32'h180});
        eq.push_back('{1'b0, A0 + 32'h200});
        eq.push_back('{1'b0, A0 + 32'h280});
        cmp_q("urgent");
        wr_urg = 1'b0;
        do_vsync();

        // outstanding write limit
        wr_req = 1'b1;
        bus.awready = 1'b1;
        bus.bvalid = 1'b0;
        n_aw = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (wr_gnt) n_aw++;
            tick();
        end
        #1;
        chk32("limit AW handshakes", n_aw, 2);
        chk1("limit awvalid blocked", bus.awvalid, 1'b0);
        tick();
        bus.bvalid = 1'b1;
        #1;
        chk1("limit awvalid during B", bus.awvalid, 1'b0);
        tick();
        bus.bvalid = 1'b0;
        #1;
        chk1("limit awvalid after B", bus.awvalid, 1'b0);
        tick();
        bus.bvalid = 1'b1;
        #1;
        chk1("third AW valid", bus.awvalid, 1'b1);
        chk32("third AW addr", bus.awaddr, A0 + 32'h300);
        chk1("third AW gnt", wr_gnt, 1'b1);
        tick();
        bus.bvalid = 1'b0;
        #1;
        chk1("idle after third AW", bus.awvalid, 1'b0);
        tick();
        #1;
        chk1("coincident B frees a slot", bus.awvalid, 1'b1);
        chk32("fourth AW addr", bus.awaddr, A0 + 32'h380);
        tick();
        wr_req = 1'b0;
        bus.bvalid = 1'b1;
        repeat (2) tick();
        do_vsync();

        // stalled AW with a vsync arriving mid-stall
        wr_req = 1'b1;
        bus.awready = 1'b0;
        bus.bvalid = 1'b0;
        #1;
        chk1("stall pre awvalid", bus.awvalid, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 3) vs = 1'b1;
            #1;
            chk1($sformatf("stall%0d awvalid", k), bus.awvalid, 1'b1);
            chk32($sformatf("stall%0d awaddr", k), bus.awaddr, A0);
            tick();
        end
        bus.awready = 1'b1;
        #1;
        chk1("stall handshake gnt", wr_gnt, 1'b1);
        chk1("no swap during stall err", err, 1'b0);
        chk1("no swap during stall ok", ok, 1'b1);
        tick();
        bus.awready = 1'b0;
        #1;
        chk1("swap cycle awvalid", bus.awvalid, 1'b0);
        tick();
        #1;
        chk1("short frame err", err, 1'b1);
        chk1("short frame rd_frame_ok", ok, 1'b0);
        tick();
        bus.awready = 1'b1;
        #1;
        chk1("new frame awvalid", bus.awvalid, 1'b1);
        chk32("new frame awaddr", bus.awaddr, A0 + 32'h200);
        chk1("new frame gnt", wr_gnt, 1'b1);
        tick();
        vs = 1'b0;
        bus.bvalid = 1'b1;
        repeat (8) tick();
        do_vsync();
        #1;
        chk1("err sticky", err, 1'b1);
        chk1("full frame ok again", ok, 1'b1);
        tick();

        // reset while an AR is pending
        rd_req = 1'b1;
        bus.arready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk1("AR pending before reset", bus.arvalid, 1'b1);
        tick();
        rst_n = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b1;
        bus.awready = 1'b1;
        #1;
        chk1("post reset arvalid", bus.arvalid, 1'b0);
        chk1("post reset rd_frame_ok", ok, 1'b0);
        chk1("post reset err", err, 1'b0);
        chk1("post reset awvalid", bus.awvalid, 1'b0);
        tick();
        #1;
        chk1("post reset AW valid", bus.awvalid, 1'b1);
        chk32("post reset AW addr", bus.awaddr, A0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
